dcache_ctrl: RTL

Sequencing controller for the L1 direct-mapped data cache: accepts one CPU load/store at a time, drives the tag memory and data array, and resolves misses against next-level memory. It is write-back, write-allocate, multi-word-line. It sits between the CPU load/store unit and the tag memory, data array and memory bus. It is the only writer of the tag memory.

---
 rtl/dcache_pkg.sv | 31 +++
 rtl/dcache_ctrl_line_xfer_ctr.sv | 29 ++
 rtl/dcache_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-slice widths for the L1 data-cache controller.
package dcache_pkg;

  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 256;
  localparam int WORD_W     = $clog2(LINE_WORDS);
  localparam int INDEX_W    = $clog2(NUM_LINES);
  localparam int TAG_W      = 32 - 2 - WORD_W - INDEX_W;
  localparam int DADDR_W    = INDEX_W + WORD_W;

  // Tag memory port: line index plus write strobe.
  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic               wr_en;
  } cache_req_t;

  // One tag memory entry.
  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } cache_tag_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } dcache_state_e;

endpackage

// File: rtl/dcache_ctrl_line_xfer_ctr.sv
// Word counter for line transfers to/from next-level memory.
module line_xfer_ctr #(
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clr_i,
  input  logic                          adv_i,
  output logic [$clog2(LINE_WORDS)-1:0] cnt_o,
  output logic                          last_o
);

  logic [$clog2(LINE_WORDS)-1:0] r_cnt;

  // Counter clears on request, otherwise steps once per accepted memory ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (adv_i) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o  = r_cnt;
  assign last_o = (r_cnt == ($clog2(LINE_WORDS))'(LINE_WORDS - 1));

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate sequencing controller for a direct-mapped L1 D-cache.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int  LINE_WORDS = 4,
  parameter int  NUM_LINES  = 256,
  localparam int WW         = $clog2(LINE_WORDS),
  localparam int IW         = $clog2(NUM_LINES),
  localparam int TW         = 32 - 2 - WW - IW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cpu_req_valid_i,
  input  logic             cpu_req_we_i,
  input  logic [31:0]      cpu_req_addr_i,
  input  logic [31:0]      cpu_req_wdata_i,
  output logic             cpu_ready_o,
  output logic             cpu_resp_valid_o,
  output logic [31:0]      cpu_resp_rdata_o,
  output cache_req_t       tag_req_o,
  output cache_tag_t       tag_wr_o,
  input  cache_tag_t       tag_rd_i,
  output logic [IW+WW-1:0] data_addr_o,
  output logic             data_we_o,
  output logic [31:0]      data_wdata_o,
  input  logic [31:0]      data_rdata_i,
  output logic             mem_req_valid_o,
  output logic             mem_req_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_rdata_i
);

  dcache_state_e r_state;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [TW-1:0] r_victim_tag;
  logic          r_resp_valid;
  logic [31:0]   r_resp_rdata;
  logic          r_mem_valid;
  logic          r_mem_we;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;

  logic [TW-1:0] w_tag;
  logic [IW-1:0] w_index;
  logic [WW-1:0] w_word;
  logic [WW-1:0] w_cnt;
  logic [WW-1:0] w_xfer_word;
  logic          w_last;
  logic          w_hit;
  logic          w_ack;
  logic          w_store_hit;
  logic          w_alloc_last;
  logic          w_unused;

  assign w_tag    = r_addr[31 -: TW];
  assign w_index  = r_addr[2+WW +: IW];
  assign w_word   = r_addr[2 +: WW];
  assign w_unused = &{1'b0, r_addr[1:0]};

  assign w_hit        = (r_state == COMPARE) && tag_rd_i.valid && (tag_rd_i.tag == w_tag);
  assign w_ack        = r_mem_valid && mem_ack_i &&
                        ((r_state == WRITEBACK) || (r_state == ALLOCATE));
  assign w_store_hit  = w_hit && r_we;
  assign w_alloc_last = (r_state == ALLOCATE) && w_ack && w_last;

  line_xfer_ctr #(.LINE_WORDS(LINE_WORDS)) u_xfer_ctr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  ((r_state == COMPARE) || (w_ack && w_last)),
    .adv_i  (w_ack),
    .cnt_o  (w_cnt),
    .last_o (w_last)
  );

  // Tag/data port steering. On a COMPARE miss the data array already points at
  // word 0 so the first write-back word can be captured on the way out of COMPARE.
  always_comb begin
    w_xfer_word     = w_hit ? w_word : w_cnt;
    data_addr_o     = {w_index, w_xfer_word};
    data_we_o       = w_store_hit || ((r_state == ALLOCATE) && w_ack);
    data_wdata_o    = '0;
    if (r_state == COMPARE)  data_wdata_o = r_wdata;
    if (r_state == ALLOCATE) data_wdata_o = mem_rdata_i;
    tag_req_o.index = w_index;
    tag_req_o.wr_en = w_store_hit || w_alloc_last;
    tag_wr_o        = '0;
    if (w_store_hit)  tag_wr_o = '{valid: 1'b1, dirty: 1'b1, tag: w_tag};
    if (w_alloc_last) tag_wr_o = '{valid: 1'b1, dirty: 1'b0, tag: w_tag};
  end

  // Main sequencer: request capture, hit/miss resolution, line write-back and fill.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_victim_tag <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_req_valid_i) begin
            r_we    <= cpu_req_we_i;
            r_addr  <= cpu_req_addr_i;
            r_wdata <= cpu_req_wdata_i;
            r_state <= COMPARE;
          end
        end
        COMPARE: begin
          if (w_hit) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_we ? 32'h0 : data_rdata_i;
            r_state      <= IDLE;
          end else if (tag_rd_i.valid && tag_rd_i.dirty) begin
            r_victim_tag <= tag_rd_i.tag;
            r_mem_valid  <= 1'b1;
            r_mem_we     <= 1'b1;
            r_mem_addr   <= {tag_rd_i.tag, w_index, w_cnt, 2'b00};
            r_mem_wdata  <= data_rdata_i;
            r_state      <= WRITEBACK;
          end else begin
            r_mem_valid  <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= {w_tag, w_index, w_cnt, 2'b00};
            r_mem_wdata  <= '0;
            r_state      <= ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (w_ack) begin
            r_mem_valid <= 1'b0;
            if (w_last) r_state <= ALLOCATE;
          end else if (!r_mem_valid) begin
            r_mem_valid <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {r_victim_tag, w_index, w_cnt, 2'b00};
            r_mem_wdata <= data_rdata_i;
          end
        end
        ALLOCATE: begin
          if (w_ack) begin
            r_mem_valid <= 1'b0;
            if (w_last) r_state <= COMPARE;
          end else if (!r_mem_valid) begin
            r_mem_valid <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {w_tag, w_index, w_cnt, 2'b00};
            r_mem_wdata <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_ready_o      = (r_state == IDLE) && !rst_i;
  assign cpu_resp_valid_o = r_resp_valid;
  assign cpu_resp_rdata_o = r_resp_rdata;
  assign mem_req_valid_o  = r_mem_valid;
  assign mem_req_we_o     = r_mem_we;
  assign mem_addr_o       = r_mem_addr;
  assign mem_wdata_o      = r_mem_wdata;

endmodule
